// File: rtl/bus_ack_responder.sv
// Queues single-cycle bus requests and answers each with a registered, delayed ack pulse.
// Optional back-to-back request checker: define BUS_ACK_RESPONDER_CHECK_EN.
module bus_ack_responder #(
    parameter int DW        = 32,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       bus_req,
    input  logic [DW-1:0]              bus_data,
    output logic                       bus_ack,
    output logic [DW-1:0]              rsp_data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       overflow,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_cnt;
    logic [TW-1:0]   w_cnt_nxt;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_bus_ack;
    logic [DW-1:0]   r_rsp_data;
    logic            r_overflow;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        if (ptr == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return ptr + AW'(1);
        end
    endfunction

    // FIFO push/pop qualification; a full queue still accepts a push when the head pops.
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == {CW{1'b0}});
        w_pop   = (r_state == ACK) && !w_empty;
        w_push  = bus_req && (!w_full || w_pop);
        w_drop  = bus_req && w_full && !w_pop;
    end

    // Next-state and delay counter; WAIT holds ACK_DELAY-2 cycles so ack lands exactly ACK_DELAY after the request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    if (ACK_DELAY <= 2) begin
                        w_state_nxt = ACK;
                        w_cnt_nxt   = {TW{1'b0}};
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = TW'(ACK_DELAY - 2);
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = {TW{1'b0}};
                end
            end
            WAIT: begin
                if (r_cnt <= TW'(1)) begin
                    w_state_nxt = ACK;
                    w_cnt_nxt   = {TW{1'b0}};
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = r_cnt - TW'(1);
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {TW{1'b0}};
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {TW{1'b0}};
            end
        endcase
    end

    // State register plus registered ack/response; the head cannot change while an ack is pending.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= IDLE;
            r_cnt      <= {TW{1'b0}};
            r_bus_ack  <= 1'b0;
            r_rsp_data <= {DW{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bus_ack <= (w_state_nxt == ACK);
            if (w_state_nxt == ACK) begin
                r_rsp_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Queue pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Queue storage.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DW{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus_data;
            end
        end
    end

`ifdef BUS_ACK_RESPONDER_CHECK_EN
    logic r_req_d;
    logic r_err;

    // Flags bus_req held high in two consecutive cycles; both requests are still queued.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_req_d <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_req_d <= bus_req;
            if (bus_req && r_req_d) begin
                r_err <= 1'b1;
                $display("bus_ack_responder: bus_req high in consecutive cycles at time %0t", $time);
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign bus_ack  = r_bus_ack;
    assign rsp_data = r_rsp_data;
    assign pending  = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bus_ack_responder.sv
// Scoreboard bench: two responders (ack delay 2 and 5) share stimulus; a timing model
// predicts every cycle's ack, response data, pending count and sticky flags.
module tb_bus_ack_responder;

    localparam int DLY_A    = 2;
    localparam int DLY_B    = 5;
    localparam int DEPTH_TB = 4;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset_l;
    logic        bus_req;
    logic [31:0] bus_data;
    logic        ack_a, ack_b;
    logic [31:0] rsp_a, rsp_b;
    logic [2:0]  pend_a, pend_b;
    logic        ovf_a, ovf_b;
    logic        err_a, err_b;

    exp_t        sb_q[$];
    int          cyc;
    int          chk_cnt;
    int          err_cnt;
    int          last_ack [2];
    logic        ovf_m [2];
    logic        err_m [2];
    logic [31:0] rsp_m [2];
`ifdef BUS_ACK_RESPONDER_CHECK_EN
    logic        prev_m [2];
`endif

    bus_ack_responder #(.DW(32), .DEPTH(DEPTH_TB), .ACK_DELAY(DLY_A)) dut_a (
        .clk(clk), .reset_l(reset_l), .bus_req(bus_req), .bus_data(bus_data),
        .bus_ack(ack_a), .rsp_data(rsp_a), .pending(pend_a), .overflow(ovf_a), .err(err_a)
    );

    bus_ack_responder #(.DW(32), .DEPTH(DEPTH_TB), .ACK_DELAY(DLY_B)) dut_b (
        .clk(clk), .reset_l(reset_l), .bus_req(bus_req), .bus_data(bus_data),
        .bus_ack(ack_b), .rsp_data(rsp_b), .pending(pend_b), .overflow(ovf_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int sb_head(input int k);
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].inst == k) return i;
        end
        return -1;
    endfunction

    function automatic int sb_count(input int k);
        int n;
        n = 0;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].inst == k) n++;
        end
        return n;
    endfunction

    task automatic model_step(input int k);
        int          h;
        int          due;
        int          dly;
        logic        exp_ack;
        logic [31:0] a_ack, a_rsp, a_pend, a_ovf, a_err;
        string       p;
        dly    = (k == 0) ? DLY_A : DLY_B;
        p      = (k == 0) ? "a" : "b";
        a_ack  = (k == 0) ? 32'(ack_a)  : 32'(ack_b);
        a_rsp  = (k == 0) ? rsp_a       : rsp_b;
        a_pend = (k == 0) ? 32'(pend_a) : 32'(pend_b);
        a_ovf  = (k == 0) ? 32'(ovf_a)  : 32'(ovf_b);
        a_err  = (k == 0) ? 32'(err_a)  : 32'(err_b);
        if (!reset_l) begin
            check_val({p, ".rst_ack"},  a_ack,  32'd0);
            check_val({p, ".rst_rsp"},  a_rsp,  32'd0);
            check_val({p, ".rst_pend"}, a_pend, 32'd0);
            check_val({p, ".rst_ovf"},  a_ovf,  32'd0);
            check_val({p, ".rst_err"},  a_err,  32'd0);
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].inst == k) sb_q.delete(i);
            end
            last_ack[k] = -1000;
            ovf_m[k]    = 1'b0;
            err_m[k]    = 1'b0;
            rsp_m[k]    = 32'd0;
`ifdef BUS_ACK_RESPONDER_CHECK_EN
            prev_m[k]   = 1'b0;
`endif
            return;
        end
        check_val({p, ".pending"},  a_pend, 32'(sb_count(k)));
        check_val({p, ".overflow"}, a_ovf,  32'(ovf_m[k]));
        check_val({p, ".err"},      a_err,  32'(err_m[k]));
        h       = sb_head(k);
        exp_ack = 1'b0;
        if (h >= 0) begin
            due = sb_q[h].cyc + dly;
            if (last_ack[k] + dly > due) due = last_ack[k] + dly;
            exp_ack = (due == cyc);
        end
        check_val({p, ".ack"}, a_ack, 32'(exp_ack));
        if (exp_ack) begin
            rsp_m[k]    = sb_q[h].data;
            sb_q.delete(h);
            last_ack[k] = cyc;
        end
        check_val({p, ".rsp"}, a_rsp, rsp_m[k]);
        if (bus_req) begin
            if (sb_count(k) == DEPTH_TB) begin
                ovf_m[k] = 1'b1;
            end else begin
                sb_q.push_back('{inst: k, cyc: cyc, data: bus_data});
            end
        end
`ifdef BUS_ACK_RESPONDER_CHECK_EN
        if (bus_req && prev_m[k]) err_m[k] = 1'b1;
        prev_m[k] = bus_req;
`endif
    endtask

    task automatic step(input logic req, input logic [31:0] d, input logic rst_l);
        @(posedge clk);
        #1;
        cyc++;
        reset_l  = rst_l;
        bus_req  = req;
        bus_data = d;
        @(negedge clk);
        model_step(0);
        model_step(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        reset_l  = 1'b0;
        bus_req  = 1'b0;
        bus_data = 32'd0;
        cyc      = 0;
        chk_cnt  = 0;
        err_cnt  = 0;
        for (int k = 0; k < 2; k++) begin
            last_ack[k] = -1000;
            ovf_m[k]    = 1'b0;
            err_m[k]    = 1'b0;
            rsp_m[k]    = 32'd0;
`ifdef BUS_ACK_RESPONDER_CHECK_EN
            prev_m[k]   = 1'b0;
`endif
        end

        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
        idle(6);

        // single request
        step(1'b1, 32'h0000_feed, 1'b1);
        idle(12);

        // back-to-back requests
        step(1'b1, 32'd1, 1'b1);
        step(1'b1, 32'd2, 1'b1);
        step(1'b1, 32'd3, 1'b1);
        idle(25);

        // ten requests at two-cycle spacing: pointer wrap and simultaneous push/pop
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b1);
            idle(1);
        end
        idle(30);

        // reset while dut_b waits
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b1, 32'h0000_0aaa, 1'b1);
        idle(1);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'h0000_0bbb, 1'b1);
        idle(10);

        // burst longer than the queue can absorb
        for (int i = 0; i < 12; i++) step(1'b1, 32'h200 + 32'(i), 1'b1);
        check_val("a.ovf_burst", 32'(ovf_a), 32'd1);
        check_val("b.ovf_burst", 32'(ovf_b), 32'd1);
        idle(45);

        // clear flags, then a double request
        step(1'b0, 32'd0, 1'b0);
        idle(5);
        step(1'b1, 32'h0000_0c01, 1'b1);
        step(1'b1, 32'h0000_0c02, 1'b1);
        idle(3);
`ifdef BUS_ACK_RESPONDER_CHECK_EN
        check_val("a.err_double", 32'(err_a), 32'd1);
`else
        check_val("a.err_double", 32'(err_a), 32'd0);
`endif
        idle(15);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 2) == 0), $urandom, 1'b1);
        end
        idle(45);

        check_val("a.drain", 32'(sb_count(0)), 32'd0);
        check_val("b.drain", 32'(sb_count(1)), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
